alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 161 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller between decode and a handshaked ALU: latches one instruction,
// requests the ALU, and commits its result, condition codes, Y or a trap.
module alu_issue_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [1:0]  issue_op,
  input  logic [5:0]  issue_op3,
  input  logic [31:0] issue_rs1,
  input  logic [31:0] issue_rs2,
  input  logic [4:0]  issue_rd,
  output logic        alu_req,
  output logic [1:0]  alu_op,
  output logic [5:0]  alu_op3,
  output logic [31:0] alu_operand1,
  output logic [31:0] alu_operand2,
  input  logic        alu_reqack,
  input  logic        alu_done,
  input  logic [31:0] alu_val,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_c,
  input  logic [31:0] alu_y,
  input  logic        alu_trap,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [3:0]  icc,
  output logic [31:0] y_reg,
  output logic        trap_valid,
  output logic [1:0]  trap_type
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] TRAP_TAG     = 2'b01;
  localparam logic [1:0] TRAP_DIV0    = 2'b10;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rd_q;

  logic accept;
  logic div_op;
  logic div_zero;
  logic cnt_hit;
  logic tag_trap;
  logic wr_ok;
  logic icc_op;
  logic y_op;

  // Divides are op3 0x0E/0x0F/0x1E/0x1F: op3[5]=0, op3[3:1]=111
  assign accept   = issue_valid && issue_ready;
  assign div_op   = (issue_op == 2'b10) && !issue_op3[5] && (issue_op3[3:1] == 3'b111);
  assign div_zero = div_op && (issue_rs2 == 32'd0);
  assign cnt_hit  = ((CNT_W+1)'(cnt) + (CNT_W+1)'(1)) == (CNT_W+1)'(TIMEOUT);

  // Commit decode on the latched instruction fields
  assign tag_trap = alu_trap && (alu_op == 2'b10) && (alu_op3[5:1] == 5'b10001);
  assign wr_ok    = ((alu_op == 2'b10) || ((alu_op == 2'b00) && (alu_op3[5:3] == 3'b100)))
                    && (rd_q != 5'd0);
  assign icc_op   = (alu_op == 2'b10) && alu_op3[4];
  assign y_op     = (alu_op == 2'b10) &&
                    ((!alu_op3[5] && (alu_op3[3:1] == 3'b101)) || (alu_op3 == 6'b100100));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rd_q         <= '0;
      issue_ready  <= 1'b1;
      alu_req      <= 1'b0;
      alu_op       <= '0;
      alu_op3      <= '0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      icc          <= '0;
      y_reg        <= '0;
      trap_valid   <= 1'b0;
      trap_type    <= '0;
    end else begin
      wb_valid   <= 1'b0;
      trap_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            alu_op       <= issue_op;
            alu_op3      <= issue_op3;
            alu_operand1 <= issue_rs1;
            alu_operand2 <= issue_rs2;
            rd_q         <= issue_rd;
            cnt          <= '0;
            if (div_zero) begin
              trap_valid <= 1'b1;
              trap_type  <= TRAP_DIV0;
            end else begin
              state       <= REQ;
              alu_req     <= 1'b1;
              issue_ready <= 1'b0;
            end
          end
        end
        REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt_hit) begin
            state       <= IDLE;
            alu_req     <= 1'b0;
            issue_ready <= 1'b1;
            trap_valid  <= 1'b1;
            trap_type   <= TRAP_TIMEOUT;
          end else if (alu_reqack) begin
            state   <= WAIT;
            alu_req <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // A result arriving on the timeout cycle still wins
          if (alu_done) begin
            state   <= WB;
            wb_rd   <= rd_q;
            wb_data <= alu_val;
            if (tag_trap) begin
              trap_valid <= 1'b1;
              trap_type  <= TRAP_TAG;
            end else begin
              wb_valid <= wr_ok;
              if (icc_op) icc <= {alu_n, alu_z, alu_v, alu_c};
              if (y_op) y_reg <= alu_y;
            end
          end else if (cnt_hit) begin
            state       <= IDLE;
            issue_ready <= 1'b1;
            trap_valid  <= 1'b1;
            trap_type   <= TRAP_TIMEOUT;
          end
        end
        WB: begin
          state       <= IDLE;
          issue_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          alu_req     <= 1'b0;
          issue_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: drives decode and a scripted ALU, checks
// outputs on the falling edge against hand-computed values.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_op;
  logic [5:0]  issue_op3;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  logic [4:0]  issue_rd;
  logic        alu_req;
  logic [1:0]  alu_op;
  logic [5:0]  alu_op3;
  logic [31:0] alu_operand1;
  logic [31:0] alu_operand2;
  logic        alu_reqack;
  logic        alu_done;
  logic [31:0] alu_val;
  logic        alu_n, alu_z, alu_v, alu_c;
  logic [31:0] alu_y;
  logic        alu_trap;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  icc;
  logic [31:0] y_reg;
  logic        trap_valid;
  logic [1:0]  trap_type;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_op3(issue_op3),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .alu_req(alu_req), .alu_op(alu_op), .alu_op3(alu_op3),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_reqack(alu_reqack), .alu_done(alu_done), .alu_val(alu_val),
    .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
    .alu_y(alu_y), .alu_trap(alu_trap),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .icc(icc), .y_reg(y_reg),
    .trap_valid(trap_valid), .trap_type(trap_type)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one instruction; returns at the falling edge after the accept edge
  task automatic accept_op(input logic [1:0] op, input logic [5:0] op3,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [4:0] rd);
    @(negedge clk);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_op3   = op3;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
    issue_rd    = rd;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  // ALU acks for one cycle, then returns its result one cycle later; ends in WB
  task automatic alu_respond(input logic [31:0] val, input logic [3:0] nzvc,
                             input logic [31:0] y, input logic trap);
    alu_reqack = 1'b1;
    @(negedge clk);
    alu_reqack = 1'b0;
    alu_done   = 1'b1;
    alu_val    = val;
    {alu_n, alu_z, alu_v, alu_c} = nzvc;
    alu_y      = y;
    alu_trap   = trap;
    @(negedge clk);
    alu_done   = 1'b0;
    alu_trap   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_op = '0; issue_op3 = '0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    alu_reqack = 1'b0; alu_done = 1'b0; alu_val = '0;
    {alu_n, alu_z, alu_v, alu_c} = 4'b0000;
    alu_y = '0; alu_trap = 1'b0;
    #23;
    check("rst_alu_req",   32'(alu_req), 0);
    check("rst_wb_valid",  32'(wb_valid), 0);
    check("rst_trap",      32'(trap_valid), 0);
    check("rst_icc",       32'(icc), 0);
    check("rst_y",         y_reg, 0);
    check("rst_trap_type", 32'(trap_type), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(issue_ready), 1);

    // ADD: plain writeback, flags from the ALU must not reach icc
    accept_op(2'b10, 6'b000000, 32'd5, 32'd7, 5'd3);
    check("add_req",   32'(alu_req), 1);
    check("add_opnd1", alu_operand1, 5);
    check("add_opnd2", alu_operand2, 7);
    check("add_ready", 32'(issue_ready), 0);
    alu_respond(32'd12, 4'b1010, 32'd0, 1'b0);
    check("add_wbv",  32'(wb_valid), 1);
    check("add_wbrd", 32'(wb_rd), 3);
    check("add_wbd",  wb_data, 12);
    check("add_icc",  32'(icc), 0);
    @(negedge clk);
    check("add_wbv_pulse", 32'(wb_valid), 0);
    check("add_ready_back", 32'(issue_ready), 1);

    // SUBcc: zero result sets Z
    accept_op(2'b10, 6'b010100, 32'd5, 32'd5, 5'd4);
    alu_respond(32'd0, 4'b0100, 32'd0, 1'b0);
    check("subcc_wbv", 32'(wb_valid), 1);
    check("subcc_wbd", wb_data, 0);
    check("subcc_icc", 32'(icc), 32'h4);

    // MULScc to r0: Y updates, no register write, icc held
    accept_op(2'b10, 6'b100100, 32'd1, 32'd2, 5'd0);
    alu_respond(32'h55, 4'b1111, 32'hCAFE0001, 1'b0);
    check("muls_wbv", 32'(wb_valid), 0);
    check("muls_y",   y_reg, 32'hCAFE0001);
    check("muls_icc", 32'(icc), 32'h4);

    // SETHI (op=00, op3[5:3]=100) writes back
    @(negedge clk);
    accept_op(2'b00, 6'b100000, 32'd0, 32'h1000, 5'd2);
    alu_respond(32'h0040_0000, 4'b0000, 32'd0, 1'b0);
    check("sethi_wbv", 32'(wb_valid), 1);
    check("sethi_wbd", wb_data, 32'h0040_0000);

    // UDIV by zero: trap without ever requesting the ALU
    @(negedge clk);
    accept_op(2'b10, 6'b001110, 32'd9, 32'd0, 5'd6);
    check("div0_trap",  32'(trap_valid), 1);
    check("div0_type",  32'(trap_type), 2);
    check("div0_req",   32'(alu_req), 0);
    check("div0_ready", 32'(issue_ready), 1);
    @(negedge clk);
    check("div0_pulse", 32'(trap_valid), 0);
    check("div0_req2",  32'(alu_req), 0);
    check("div0_wbv",   32'(wb_valid), 0);

    // TADDccTV with tag overflow: trap, nothing committed
    accept_op(2'b10, 6'b100010, 32'd1, 32'd2, 5'd5);
    alu_respond(32'd3, 4'b1111, 32'd7, 1'b1);
    check("tag_trap", 32'(trap_valid), 1);
    check("tag_type", 32'(trap_type), 1);
    check("tag_wbv",  32'(wb_valid), 0);
    check("tag_icc",  32'(icc), 32'h4);
    check("tag_y",    y_reg, 32'hCAFE0001);
    @(negedge clk);
    check("tag_type_hold", 32'(trap_type), 1);
    check("tag_pulse",     32'(trap_valid), 0);

    // alu_done together with the ack in REQ is ignored
    accept_op(2'b10, 6'b000000, 32'd1, 32'd1, 5'd9);
    alu_reqack = 1'b1; alu_done = 1'b1; alu_val = 32'd99;
    @(negedge clk);
    alu_reqack = 1'b0; alu_val = 32'd42;
    check("early_done_wbv", 32'(wb_valid), 0);
    check("early_done_req", 32'(alu_req), 0);
    @(negedge clk);
    alu_done = 1'b0;
    check("late_done_wbv", 32'(wb_valid), 1);
    check("late_done_wbd", wb_data, 42);

    // Timeout: ack withheld, alu_req high for exactly TIMEOUT cycles
    @(negedge clk);
    accept_op(2'b10, 6'b000000, 32'd1, 32'd1, 5'd6);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!alu_req) break;
      n++;
      @(negedge clk);
    end
    check("tmo_cycles", 32'(n), 16);
    check("tmo_trap",   32'(trap_valid), 1);
    check("tmo_type",   32'(trap_type), 3);
    alu_done = 1'b1; alu_val = 32'd77;
    {alu_n, alu_z, alu_v, alu_c} = 4'b1001;
    @(negedge clk);
    alu_done = 1'b0;
    check("tmo_late_wbv", 32'(wb_valid), 0);
    @(negedge clk);
    check("tmo_late_wbv2", 32'(wb_valid), 0);
    check("tmo_icc",       32'(icc), 32'h4);
    check("tmo_ready",     32'(issue_ready), 1);

    // Reset while waiting on the ALU
    accept_op(2'b10, 6'b010000, 32'd1, 32'd1, 5'd7);
    alu_reqack = 1'b1;
    @(negedge clk);
    alu_reqack = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstw_req", 32'(alu_req), 0);
    check("rstw_icc", 32'(icc), 0);
    check("rstw_y",   y_reg, 0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    alu_done = 1'b1; alu_val = 32'd5;
    @(negedge clk);
    alu_done = 1'b0;
    check("rstw_wbv",   32'(wb_valid), 0);
    check("rstw_ready", 32'(issue_ready), 1);
    @(negedge clk);
    check("rstw_wbv2",  32'(wb_valid), 0);
    check("rstw_icc2",  32'(icc), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
